instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch_pkg.sv | 15 +
 rtl/instruction_fetch.sv | 123 ++++++++++++
 tb/tb_instruction_fetch.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state type,
// instruction size in bytes and the default reset fetch address.
package instruction_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_e;

    localparam int          INSTR_BYTES      = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: issues one memory request at a time, buffers the
// returned word and offers it to the decoder. A redirect overrides every
// other activity; a response already in flight when a redirect lands in WAIT
// is remembered via the drop flag and thrown away when it arrives.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc
);

    fetch_state_e    r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_drop;
    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] r_instr_pc;

    fetch_state_e    w_state_nxt;
    logic [XLEN-1:0] w_pc_nxt;
    logic            w_drop_nxt;
    logic [XLEN-1:0] w_instr_nxt;
    logic [XLEN-1:0] w_instr_pc_nxt;
    logic [XLEN-1:0] w_redir_pc;
    logic [XLEN-1:0] w_pc_inc;

    // Redirect targets are forced to instruction alignment; pc wraps naturally.
    assign w_redir_pc = redirect_pc & ~XLEN'(INSTR_BYTES - 1);
    assign w_pc_inc   = r_pc + XLEN'(INSTR_BYTES);

    // A redirect suppresses both handshakes in the cycle it is seen.
    assign imem_req_valid = (r_state == ST_REQ)  && !redirect_valid;
    assign instr_valid    = (r_state == ST_HOLD) && !redirect_valid;
    assign imem_addr      = r_pc;
    assign instr          = r_instr;
    assign instr_pc       = r_instr_pc;

    // Next-state and next-register computation; redirect takes priority in every state.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_drop_nxt     = r_drop;
        w_instr_nxt    = r_instr;
        w_instr_pc_nxt = r_instr_pc;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_REQ;
                if (redirect_valid) begin
                    w_pc_nxt = w_redir_pc;
                end
            end
            ST_REQ: begin
                if (redirect_valid) begin
                    w_pc_nxt = w_redir_pc;
                end else if (imem_req_ready) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    w_pc_nxt = w_redir_pc;
                    if (imem_rsp_valid) begin
                        // The arriving word belongs to the old path; nothing left in flight.
                        w_drop_nxt  = 1'b0;
                        w_state_nxt = ST_REQ;
                    end else begin
                        w_drop_nxt = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    if (r_drop) begin
                        w_drop_nxt  = 1'b0;
                        w_state_nxt = ST_REQ;
                    end else begin
                        w_instr_nxt    = imem_rsp_data;
                        w_instr_pc_nxt = r_pc;
                        w_pc_nxt       = w_pc_inc;
                        w_state_nxt    = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    w_pc_nxt    = w_redir_pc;
                    w_state_nxt = ST_REQ;
                end else if (instr_ready) begin
                    w_state_nxt = ST_REQ;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, pc, drop flag and instruction buffer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_pc       <= RESET_PC;
            r_drop     <= 1'b0;
            r_instr    <= '0;
            r_instr_pc <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_drop     <= w_drop_nxt;
            r_instr    <= w_instr_nxt;
            r_instr_pc <= w_instr_pc_nxt;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a behavioural memory plus a transaction-level
// model of which fetch address comes next and which word, if any, the
// decoder is owed. Directed scenarios first, then a randomized run.
module tb_instruction_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    always #5 clk = ~clk;

    instruction_fetch #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Model state: next address the fetcher owes, outstanding request, owed word.
    logic [31:0] exp_req = RST_PC;
    bit          busy = 0;
    bit          live = 0;
    bit          held = 0;
    logic [31:0] held_pc = 32'h0;
    logic [31:0] mem_addr = 32'h0;
    int          cnt = 0;
    int          lat_min = 0;
    int          lat_max = 0;
    bit          acc_evt = 0;
    bit          hand_evt = 0;
    logic [31:0] acc_addr = 32'h0;
    logic [31:0] hand_pc = 32'h0;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock of stimulus, checking and model update.
    task automatic step(input bit redir, input logic [31:0] rpc, input bit rq_rdy, input bit irdy);
        bit rsp;
        @(negedge clk);
        cyc++;
        rsp = busy && (cnt == 0);
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_req_ready = rq_rdy;
        instr_ready    = irdy;
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? memfn(mem_addr) : $urandom;
        #1;
        acc_evt  = 0;
        hand_evt = 0;
        chk("instr_valid", 32'(instr_valid), 32'(held && !redir));
        if (redir || busy || held) chk("req_quiet", 32'(imem_req_valid), 32'h0);
        if (imem_req_valid) chk("req_addr", imem_addr, exp_req);
        if (held) begin
            chk("instr", instr, memfn(held_pc));
            chk("instr_pc", instr_pc, held_pc);
        end
        if (held && !redir && irdy) begin
            held     = 0;
            hand_evt = 1;
            hand_pc  = held_pc;
            exp_req  = held_pc + 32'd4;
        end
        if (rsp) begin
            busy = 0;
            if (live) begin
                held    = 1;
                held_pc = mem_addr;
            end
            live = 0;
        end else if (busy) begin
            cnt--;
        end
        if (imem_req_valid && rq_rdy) begin
            busy     = 1;
            live     = 1;
            mem_addr = imem_addr;
            cnt      = $urandom_range(lat_max, lat_min);
            acc_evt  = 1;
            acc_addr = imem_addr;
        end
        if (redir) begin
            live    = 0;
            held    = 0;
            exp_req = rpc & ~32'h3;
        end
    endtask

    task automatic apply_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b0;
        instr_ready    = 1'b0;
        imem_rsp_valid = 1'b0;
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
        chk("rst_instr_valid", 32'(instr_valid), 32'h0);
        chk("rst_addr", imem_addr, RST_PC);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        busy    = 0;
        live    = 0;
        held    = 0;
        exp_req = RST_PC;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Steps with the given controls until a request is accepted or the budget runs out.
    task automatic wait_accept(input string tag, input int budget, output bit saw_hand);
        int k;
        k = 0;
        saw_hand = 0;
        do begin
            step(0, 32'h0, 1, 1);
            if (hand_evt) saw_hand = 1;
            k++;
        end while (!acc_evt && k < budget);
        if (!acc_evt) chk({tag, "_timeout"}, 32'h0, 32'h1);
    endtask

    task automatic wait_held(input string tag, input int budget);
        int k;
        k = 0;
        while (!held && k < budget) begin
            step(0, 32'h0, 1, 0);
            k++;
        end
        if (!held) chk({tag, "_timeout"}, 32'h0, 32'h1);
    endtask

    initial begin
        int          hcyc[$];
        logic [31:0] hpcs[$];
        logic [31:0] accs[$];
        logic [31:0] cap_i;
        logic [31:0] cap_p;
        bit          sh;

        apply_reset();

        // Zero-wait memory, decoder always ready: 0,4,8 every 3 cycles.
        lat_min = 0;
        lat_max = 0;
        for (int k = 0; k < 40 && hcyc.size() < 3; k++) begin
            step(0, 32'h0, 1, 1);
            if (acc_evt) accs.push_back(acc_addr);
            if (hand_evt) begin
                hcyc.push_back(cyc);
                hpcs.push_back(hand_pc);
            end
        end
        if (hcyc.size() < 3) begin
            chk("cadence_timeout", 32'(hcyc.size()), 32'd3);
        end else begin
            for (int i = 0; i < 3; i++) begin
                chk("seq_req_addr", accs[i], 32'(i * 4));
                chk("seq_instr_pc", hpcs[i], 32'(i * 4));
            end
            chk("cadence_gap1", 32'(hcyc[1] - hcyc[0]), 32'd3);
            chk("cadence_gap2", 32'(hcyc[2] - hcyc[1]), 32'd3);
        end

        // Decoder stalls five cycles in HOLD: word stays put, no new request.
        lat_max = 2;
        wait_held("stall", 20);
        step(0, 32'h0, 1, 0);
        cap_i = instr;
        cap_p = instr_pc;
        for (int k = 0; k < 5; k++) begin
            step(0, 32'h0, 1, 0);
            chk("stall_instr", instr, cap_i);
            chk("stall_instr_pc", instr_pc, cap_p);
            chk("stall_no_req", 32'(imem_req_valid), 32'h0);
        end
        step(0, 32'h0, 1, 1);
        chk("stall_release", 32'(hand_evt), 32'h1);

        // Redirect to 0x103 while waiting; response arrives two cycles later and is dropped.
        lat_min = 2;
        lat_max = 2;
        wait_accept("wait_redir_pre", 20, sh);
        step(1, 32'h0000_0103, 1, 1);
        wait_accept("wait_redir", 20, sh);
        chk("wait_redir_addr", acc_addr, 32'h0000_0100);
        chk("wait_redir_nohand", 32'(sh), 32'h0);

        // Redirect to 0x200 in HOLD while decoder is ready: no handoff.
        lat_min = 0;
        lat_max = 1;
        wait_held("hold_redir", 20);
        step(1, 32'h0000_0200, 1, 1);
        chk("hold_redir_nohand", 32'(hand_evt), 32'h0);
        wait_accept("hold_redir", 20, sh);
        chk("hold_redir_addr", acc_addr, 32'h0000_0200);
        chk("hold_redir_nohand2", 32'(sh), 32'h0);

        // Fetch at the top of the address space wraps to zero.
        step(1, 32'hFFFF_FFFC, 1, 1);
        wait_accept("wrap_a", 20, sh);
        chk("wrap_first", acc_addr, 32'hFFFF_FFFC);
        wait_accept("wrap_b", 20, sh);
        chk("wrap_second", acc_addr, 32'h0000_0000);

        // Asynchronous reset in WAIT, then fetch restarts at the reset address.
        lat_min = 5;
        lat_max = 5;
        wait_accept("rst_wait_pre", 20, sh);
        step(0, 32'h0, 1, 1);
        #1;
        apply_reset();
        lat_min = 0;
        lat_max = 1;
        wait_accept("rst_restart", 20, sh);
        chk("rst_restart_addr", acc_addr, RST_PC);

        // Randomized traffic against the model.
        lat_min = 0;
        lat_max = 3;
        for (int k = 0; k < 3000; k++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(7, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : $urandom;
            step(($urandom_range(15, 0) == 0), rpc, ($urandom_range(3, 0) != 0), ($urandom_range(2, 0) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
